// File: rtl/csr_hpm_counter_bank.sv
// Machine-mode counter bank: mcycle, minstret, NUM_HPM event counters, inhibit, event selects, overflow/LCOF.
// Latency: CSR reads are combinational on registered state; commit/event inputs are registered once, then counted.
// Backpressure: none; every CSR access and every increment completes in the cycle it is presented.
module csr_hpm_counter_bank #(
    parameter int NUM_HPM         = 4,
    parameter int NUM_EVENTS      = 8,
    parameter int EVENT_INC_WIDTH = 3,
    parameter int COMMIT_WIDTH    = 3,
    parameter int COUNTER_WIDTH   = 64,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [11:0]                           csrNumber,
    input  logic                                  csrWE,
    input  logic [1:0]                            csrCode,
    input  logic [DATA_WIDTH-1:0]                 csrWriteIn,
    output logic [DATA_WIDTH-1:0]                 csrReadOut,
    output logic                                  csrHit,
    input  logic [COMMIT_WIDTH-1:0]               commitNum,
    input  logic [NUM_EVENTS*EVENT_INC_WIDTH-1:0] eventInc,
    output logic                                  lcofReq
);
    localparam int SELW = $clog2(NUM_EVENTS + 1);
    localparam int HIW  = COUNTER_WIDTH - 32;
    localparam int INHW = 3 + NUM_HPM;
    localparam int EVW  = NUM_EVENTS * EVENT_INC_WIDTH;
    localparam int CW1  = COUNTER_WIDTH + 1;
    // mcountinhibit bit 1 has no counter behind it
    localparam logic [INHW-1:0] INH_MASK = ~INHW'(2);

    logic [COUNTER_WIDTH-1:0] mcycle_q;
    logic [COUNTER_WIDTH-1:0] minstret_q;
    logic [COUNTER_WIDTH-1:0] hpm_q [NUM_HPM];
    logic [SELW-1:0]          sel_q [NUM_HPM];
    logic [NUM_HPM-1:0]       of_q;
    logic [INHW-1:0]          inh_q;
    logic [COMMIT_WIDTH-1:0]  commit_q;
    logic [EVW-1:0]           event_q;
    logic                     lcof_q;

    logic                     hit_inh;
    logic                     hit_cyc_lo;
    logic                     hit_cyc_hi;
    logic                     hit_ins_lo;
    logic                     hit_ins_hi;
    logic [NUM_HPM-1:0]       hit_evt;
    logic [NUM_HPM-1:0]       hit_hpm_lo;
    logic [NUM_HPM-1:0]       hit_hpm_hi;

    logic [DATA_WIDTH-1:0]    rd_val;
    logic [DATA_WIDTH-1:0]    wv;
    logic                     wr;

    logic [COUNTER_WIDTH-1:0]   mcycle_d;
    logic [COUNTER_WIDTH-1:0]   minstret_d;
    logic [COUNTER_WIDTH-1:0]   hpm_d   [NUM_HPM];
    logic [SELW-1:0]            sel_d   [NUM_HPM];
    logic [EVENT_INC_WIDTH-1:0] hpm_inc [NUM_HPM];
    logic [COUNTER_WIDTH:0]     hpm_sum [NUM_HPM];
    logic [NUM_HPM-1:0]         of_set;
    logic [NUM_HPM-1:0]         of_d;
    logic [INHW-1:0]            inh_d;

    function automatic logic [DATA_WIDTH-1:0] lo_half(input logic [COUNTER_WIDTH-1:0] c);
        return DATA_WIDTH'(c[31:0]);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] hi_half(input logic [COUNTER_WIDTH-1:0] c);
        return DATA_WIDTH'(c[COUNTER_WIDTH-1:32]);
    endfunction

    // Replace one half of a counter, leaving the other half untouched.
    function automatic logic [COUNTER_WIDTH-1:0] put_half(input logic [COUNTER_WIDTH-1:0] c,
                                                          input logic                     hi,
                                                          input logic [DATA_WIDTH-1:0]    v);
        logic [COUNTER_WIDTH-1:0] r;
        r = c;
        if (hi)
            r[COUNTER_WIDTH-1:32] = v[HIW-1:0];
        else
            r[31:0] = v[31:0];
        return r;
    endfunction

    always_comb begin
        hit_inh    = (csrNumber == 12'h320);
        hit_cyc_lo = (csrNumber == 12'hB00);
        hit_cyc_hi = (csrNumber == 12'hB80);
        hit_ins_lo = (csrNumber == 12'hB02);
        hit_ins_hi = (csrNumber == 12'hB82);
        for (int i = 0; i < NUM_HPM; i++) begin
            hit_evt[i]    = (csrNumber == 12'h323 + 12'(i));
            hit_hpm_lo[i] = (csrNumber == 12'hB03 + 12'(i));
            hit_hpm_hi[i] = (csrNumber == 12'hB83 + 12'(i));
        end
    end

    assign csrHit = hit_inh | hit_cyc_lo | hit_cyc_hi | hit_ins_lo | hit_ins_hi |
                    (|hit_evt) | (|hit_hpm_lo) | (|hit_hpm_hi);

    always_comb begin
        rd_val = '0;
        if (hit_inh)    rd_val = DATA_WIDTH'(inh_q);
        if (hit_cyc_lo) rd_val = lo_half(mcycle_q);
        if (hit_cyc_hi) rd_val = hi_half(mcycle_q);
        if (hit_ins_lo) rd_val = lo_half(minstret_q);
        if (hit_ins_hi) rd_val = hi_half(minstret_q);
        for (int i = 0; i < NUM_HPM; i++) begin
            if (hit_evt[i]) begin
                rd_val[31]       = of_q[i];
                rd_val[SELW-1:0] = sel_q[i];
            end
            if (hit_hpm_lo[i]) rd_val = lo_half(hpm_q[i]);
            if (hit_hpm_hi[i]) rd_val = hi_half(hpm_q[i]);
        end
    end

    assign csrReadOut = rd_val;

    always_comb begin
        case (csrCode)
            2'd1:    wv = rd_val | csrWriteIn;
            2'd2:    wv = rd_val & ~csrWriteIn;
            default: wv = csrWriteIn;
        endcase
    end

    assign wr = csrWE & csrHit;

    // Out-of-range selects (0 or above NUM_EVENTS) match no slice and count nothing.
    always_comb begin
        for (int i = 0; i < NUM_HPM; i++) begin
            hpm_inc[i] = '0;
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (sel_q[i] == SELW'(k + 1))
                    hpm_inc[i] = event_q[k*EVENT_INC_WIDTH +: EVENT_INC_WIDTH];
            end
            hpm_sum[i] = {1'b0, hpm_q[i]} + CW1'(hpm_inc[i]);
        end
    end

    // A write to either half of a counter drops that counter's increment, carry and overflow.
    always_comb begin
        mcycle_d = mcycle_q;
        if (wr && (hit_cyc_lo || hit_cyc_hi))
            mcycle_d = put_half(mcycle_q, hit_cyc_hi, wv);
        else if (!inh_q[0])
            mcycle_d = mcycle_q + COUNTER_WIDTH'(1);

        minstret_d = minstret_q;
        if (wr && (hit_ins_lo || hit_ins_hi))
            minstret_d = put_half(minstret_q, hit_ins_hi, wv);
        else if (!inh_q[2])
            minstret_d = minstret_q + COUNTER_WIDTH'(commit_q);

        for (int i = 0; i < NUM_HPM; i++) begin
            hpm_d[i]  = hpm_q[i];
            of_set[i] = 1'b0;
            if (wr && (hit_hpm_lo[i] || hit_hpm_hi[i])) begin
                hpm_d[i] = put_half(hpm_q[i], hit_hpm_hi[i], wv);
            end else if (!inh_q[3+i]) begin
                hpm_d[i]  = hpm_sum[i][COUNTER_WIDTH-1:0];
                of_set[i] = hpm_sum[i][COUNTER_WIDTH];
            end

            // A hardware overflow in the same cycle beats a software clear of OF.
            sel_d[i] = sel_q[i];
            of_d[i]  = of_q[i] | of_set[i];
            if (wr && hit_evt[i]) begin
                sel_d[i] = wv[SELW-1:0];
                of_d[i]  = wv[31] | of_set[i];
            end
        end

        inh_d = inh_q;
        if (wr && hit_inh)
            inh_d = wv[INHW-1:0] & INH_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
            of_q       <= '0;
            inh_q      <= '0;
            commit_q   <= '0;
            event_q    <= '0;
            lcof_q     <= 1'b0;
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_q[i] <= '0;
                sel_q[i] <= '0;
            end
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            of_q       <= of_d;
            inh_q      <= inh_d;
            commit_q   <= commitNum;
            event_q    <= eventInc;
            lcof_q     <= |of_d;
            for (int i = 0; i < NUM_HPM; i++) begin
                hpm_q[i] <= hpm_d[i];
                sel_q[i] <= sel_d[i];
            end
        end
    end

    assign lcofReq = lcof_q;

endmodule

// File: tb/tb_csr_hpm_counter_bank.sv
// Bench for csr_hpm_counter_bank: directed scenarios with literal expectations plus
// randomized CSR traffic checked every cycle against a behavioural reference model.
module tb_csr_hpm_counter_bank;
    localparam int NH = 4;
    localparam int NE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] csrNumber = '0;
    logic        csrWE = 1'b0;
    logic [1:0]  csrCode = '0;
    logic [31:0] csrWriteIn = '0;
    logic [31:0] csrReadOut;
    logic        csrHit;
    logic [2:0]  commitNum = '0;
    logic [23:0] eventInc = '0;
    logic        lcofReq;

    always #5 clk = ~clk;

    csr_hpm_counter_bank dut (
        .clk        (clk),
        .rst        (rst),
        .csrNumber  (csrNumber),
        .csrWE      (csrWE),
        .csrCode    (csrCode),
        .csrWriteIn (csrWriteIn),
        .csrReadOut (csrReadOut),
        .csrHit     (csrHit),
        .commitNum  (commitNum),
        .eventInc   (eventInc),
        .lcofReq    (lcofReq)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit rst_req = 1'b1;

    // Reference state: index 0 mcycle, 2 minstret, 3..6 hpm counters (index 1 unused).
    longint unsigned m_cnt [7];
    logic [3:0]      m_sel [NH];
    bit              m_of  [NH];
    logic [31:0]     m_inh;
    int              m_pc;
    int              m_pe  [NE];
    bit              m_lcof;
    bit              m_valid = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a, output bit hit);
        int n;
        hit = 1'b1;
        if (a == 12'h320) return m_inh;
        n = int'(a) - 'h323;
        if (n >= 0 && n < NH) return {m_of[n], 27'd0, m_sel[n]};
        n = int'(a) - 'hB00;
        if (n >= 0 && n <= 6 && n != 1) return m_cnt[n][31:0];
        n = int'(a) - 'hB80;
        if (n >= 0 && n <= 6 && n != 1) return m_cnt[n][63:32];
        hit = 1'b0;
        return 32'd0;
    endfunction

    function automatic void m_step();
        logic [31:0]     rv, wv;
        bit              hit, wr;
        longint unsigned inc, old;
        bit              hw [NH];
        int              a, s;
        if (rst) begin
            foreach (m_cnt[n]) m_cnt[n] = 0;
            for (int i = 0; i < NH; i++) begin m_sel[i] = 0; m_of[i] = 0; end
            for (int k = 0; k < NE; k++) m_pe[k] = 0;
            m_inh = 0; m_pc = 0; m_lcof = 0; m_valid = 1'b1;
            return;
        end
        rv = m_read(csrNumber, hit);
        case (csrCode)
            2'd1:    wv = rv | csrWriteIn;
            2'd2:    wv = rv & ~csrWriteIn;
            default: wv = csrWriteIn;
        endcase
        wr = csrWE && hit;
        a  = int'(csrNumber);
        for (int i = 0; i < NH; i++) hw[i] = 1'b0;
        for (int n = 0; n < 7; n++) begin
            if (n == 1) continue;
            if (n == 0) inc = 1;
            else if (n == 2) inc = longint'(m_pc);
            else begin
                s = int'(m_sel[n-3]);
                inc = (s >= 1 && s <= NE) ? longint'(m_pe[s-1]) : 0;
            end
            if (wr && a == 'hB00 + n) m_cnt[n] = {m_cnt[n][63:32], wv};
            else if (wr && a == 'hB80 + n) m_cnt[n] = {wv, m_cnt[n][31:0]};
            else if (!m_inh[n]) begin
                old = m_cnt[n];
                m_cnt[n] = m_cnt[n] + inc;
                if (n >= 3 && m_cnt[n] < old) hw[n-3] = 1'b1;
            end
        end
        for (int i = 0; i < NH; i++) begin
            if (hw[i]) m_of[i] = 1'b1;
            if (wr && a == 'h323 + i) begin
                m_sel[i] = wv[3:0];
                m_of[i]  = wv[31] | hw[i];
            end
        end
        if (wr && a == 'h320) m_inh = wv & 32'h7D;
        m_pc = int'(commitNum);
        for (int k = 0; k < NE; k++) m_pe[k] = int'(eventInc[k*3 +: 3]);
        m_lcof = 1'b0;
        for (int i = 0; i < NH; i++) m_lcof |= m_of[i];
    endfunction

    // One clock cycle: drive at negedge, compare before the edge, advance the model at the edge.
    task automatic drive(input logic [11:0] a, input logic we, input logic [1:0] code,
                         input logic [31:0] d, input logic [2:0] cn, input logic [23:0] ev,
                         input bit lit = 1'b0, input logic [31:0] lit_rd = 32'd0,
                         input string nm = "", input bit lit_hit = 1'b1);
        logic [31:0] mr;
        bit          mh;
        @(negedge clk);
        rst = rst_req; csrNumber = a; csrWE = we; csrCode = code;
        csrWriteIn = d; commitNum = cn; eventInc = ev;
        #1;
        if (m_valid) begin
            mr = m_read(a, mh);
            chk("model_read", csrReadOut, mr);
            chk("model_hit", {31'd0, csrHit}, {31'd0, mh});
            chk("model_lcof", {31'd0, lcofReq}, {31'd0, m_lcof});
        end
        if (lit) begin
            chk(nm, csrReadOut, lit_rd);
            chk({nm, "_hit"}, {31'd0, csrHit}, {31'd0, lit_hit});
        end
        @(posedge clk);
        m_step();
    endtask

    task automatic wr_csr(input logic [11:0] a, input logic [1:0] code, input logic [31:0] d);
        drive(a, 1'b1, code, d, 3'd0, 24'd0);
    endtask

    task automatic rd_lit(input logic [11:0] a, input logic [31:0] exp, input string nm);
        drive(a, 1'b0, 2'd0, 32'd0, 3'd0, 24'd0, 1'b1, exp, nm);
    endtask

    logic [11:0] addrs [$];

    initial begin
        addrs = '{12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327, 12'h3A0,
                  12'hB00, 12'hB80, 12'hB01, 12'hB02, 12'hB82, 12'hB03, 12'hB04,
                  12'hB05, 12'hB06, 12'hB07, 12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hB1F};

        rst_req = 1'b1;
        drive(12'h0, 1'b0, 2'd0, 32'd0, 3'd0, 24'd0);
        drive(12'h0, 1'b0, 2'd0, 32'd0, 3'd0, 24'd0);
        rst_req = 1'b0;

        // Idle counting after reset
        for (int k = 0; k < 10; k++) rd_lit(12'hB00, 32'(k), "mcycle_idle");
        rd_lit(12'hB00, 32'd10, "mcycle_10");
        rd_lit(12'hB02, 32'd0, "minstret_idle");
        rd_lit(12'hB03, 32'd0, "hpm3_idle");
        #1 chk("lcof_idle", {31'd0, lcofReq}, 32'd0);

        // Two-cycle event latency
        wr_csr(12'h323, 2'd0, 32'd2);
        drive(12'hB03, 1'b0, 2'd0, 32'd0, 3'd0, 24'h000018, 1'b1, 32'd0, "hpm3_t");
        rd_lit(12'hB03, 32'd0, "hpm3_t1");
        rd_lit(12'hB03, 32'd3, "hpm3_t2");
        rd_lit(12'hB04, 32'd0, "hpm4_untouched");

        // Wrap sets OF and lcofReq; clearing OF drops lcofReq
        wr_csr(12'h323, 2'd0, 32'd1);
        wr_csr(12'hB03, 2'd0, 32'hFFFF_FFFF);
        wr_csr(12'hB83, 2'd0, 32'hFFFF_FFFF);
        drive(12'hB03, 1'b0, 2'd0, 32'd0, 3'd0, 24'h000002);
        rd_lit(12'hB03, 32'hFFFF_FFFF, "hpm3_premax");
        rd_lit(12'hB03, 32'd1, "hpm3_wrapped");
        rd_lit(12'hB83, 32'd0, "hpm3_hi_wrapped");
        rd_lit(12'h323, 32'h8000_0001, "evt3_of");
        #1 chk("lcof_set", {31'd0, lcofReq}, 32'd1);
        wr_csr(12'h323, 2'd2, 32'h8000_0000);
        #1 chk("lcof_clr", {31'd0, lcofReq}, 32'd0);
        rd_lit(12'h323, 32'd1, "evt3_of_clr");

        // Inhibit freezes mcycle/minstret; release resumes one edge later
        wr_csr(12'hB02, 2'd0, 32'd0);
        wr_csr(12'hB82, 2'd0, 32'd0);
        drive(12'h320, 1'b1, 2'd1, 32'd5, 3'd2, 24'd0);
        for (int k = 0; k < 4; k++)
            drive(12'hB02, 1'b0, 2'd0, 32'd0, 3'd2, 24'd0, 1'b1, 32'd0, "minstret_frozen");
        rd_lit(12'h320, 32'd5, "inhibit_rd");
        drive(12'h320, 1'b1, 2'd2, 32'd5, 3'd2, 24'd0);
        drive(12'hB02, 1'b0, 2'd0, 32'd0, 3'd2, 24'd0, 1'b1, 32'd0, "minstret_r0");
        drive(12'hB02, 1'b0, 2'd0, 32'd0, 3'd2, 24'd0, 1'b1, 32'd2, "minstret_r1");
        drive(12'hB02, 1'b0, 2'd0, 32'd0, 3'd0, 24'd0, 1'b1, 32'd4, "minstret_r2");

        // Write wins over a simultaneous increment; other half holds
        wr_csr(12'h324, 2'd0, 32'd3);
        wr_csr(12'hB84, 2'd0, 32'hAB);
        drive(12'hB04, 1'b0, 2'd0, 32'd0, 3'd0, 24'h000140);
        drive(12'hB04, 1'b1, 2'd0, 32'h100, 3'd0, 24'd0);
        rd_lit(12'hB04, 32'h100, "hpm4_wr_lo");
        rd_lit(12'hB84, 32'hAB, "hpm4_hi_hold");

        // Unimplemented addresses and out-of-range select
        drive(12'h3A0, 1'b1, 2'd0, 32'hFFFF_FFFF, 3'd0, 24'd0, 1'b1, 32'd0, "unimpl_3a0", 1'b0);
        drive(12'hB1F, 1'b1, 2'd0, 32'hFFFF_FFFF, 3'd0, 24'd0, 1'b1, 32'd0, "unimpl_b1f", 1'b0);
        rd_lit(12'h320, 32'd0, "inhibit_kept");
        wr_csr(12'h325, 2'd0, 32'd9);
        rd_lit(12'h325, 32'd9, "evt5_sel9");
        for (int k = 0; k < 5; k++) drive(12'hB05, 1'b0, 2'd0, 32'd0, 3'd0, 24'hFFFFFF);
        rd_lit(12'hB05, 32'd0, "hpm5_sel9");

        // Randomized traffic, with occasional mid-run resets
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] d;
            rst_req = ($urandom_range(0, 599) == 0);
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'hFFFF_FFFF;
                2:       d = 32'hFFFF_FFF0;
                default: d = 32'($urandom_range(0, 15));
            endcase
            drive(addrs[$urandom_range(0, addrs.size() - 1)], ($urandom_range(0, 2) == 0),
                  2'($urandom_range(0, 3)), d, 3'($urandom_range(0, 7)), 24'($urandom));
        end
        rst_req = 1'b0;
        drive(12'hB00, 1'b0, 2'd0, 32'd0, 3'd0, 24'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
